// File: rtl/ctrl_lock_decoder.sv
// Multi-channel enable/lock control decoder with registered per-channel outputs.
// Optional saturating rejected-command counter enabled by defining CTRL_LOCK_ERRCNT_EN.
module ctrl_lock_decoder #(
    parameter int CTRL_W = 4,
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic              cmd_bcast,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [CTRL_W-1:0] cmd_code,
    output logic [NUM_CH-1:0] enable_all,
    output logic [NUM_CH-1:0] lock_on,
    output logic              cmd_err,
    output logic              all_locked,
    output logic [7:0]        err_cnt
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ENABLED  = 2'd1,
        ST_LOCKED   = 2'd2
    } ch_state_t;

    localparam logic [CTRL_W-1:0] CODE_ENABLE  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] CODE_DISABLE = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] CODE_LOCK    = CTRL_W'(3);

    ch_state_t         state_q [NUM_CH];
    ch_state_t         state_d [NUM_CH];
    logic [NUM_CH-1:0] enable_q, enable_d;
    logic [NUM_CH-1:0] lock_q, lock_d;
    logic              cmd_err_q, err_d;
    logic              all_locked_q;
    logic              code_ok, any_unlocked, tgt_unlocked, target_ok, apply;

    always_comb begin
        state_d      = state_q;
        code_ok      = (cmd_code == CODE_ENABLE) || (cmd_code == CODE_DISABLE) ||
                       (cmd_code == CODE_LOCK);
        any_unlocked = 1'b0;
        tgt_unlocked = 1'b0;
        // An out-of-range unicast index never matches a channel, so it is rejected here too
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (state_q[i] != ST_LOCKED) begin
                any_unlocked = 1'b1;
                if (cmd_ch == CH_W'(i)) tgt_unlocked = 1'b1;
            end
        end
        target_ok = cmd_bcast ? any_unlocked : tgt_unlocked;
        apply     = cmd_valid && code_ok && target_ok;
        err_d     = cmd_valid && !(code_ok && target_ok);

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (apply && (state_q[i] != ST_LOCKED) && (cmd_bcast || (cmd_ch == CH_W'(i)))) begin
                case (cmd_code)
                    CODE_ENABLE:  state_d[i] = ST_ENABLED;
                    CODE_DISABLE: state_d[i] = ST_DISABLED;
                    CODE_LOCK:    state_d[i] = ST_LOCKED;
                    default:      state_d[i] = state_q[i];
                endcase
            end
        end

        enable_d = '0;
        lock_d   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            enable_d[i] = (state_d[i] == ST_ENABLED);
            lock_d[i]   = (state_d[i] == ST_LOCKED);
        end
    end

    // Outputs are decoded from next state and registered so each enable is a single flop
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) state_q[i] <= ST_DISABLED;
            enable_q     <= '0;
            lock_q       <= '0;
            cmd_err_q    <= 1'b0;
            all_locked_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable_d;
            lock_q       <= lock_d;
            cmd_err_q    <= err_d;
            all_locked_q <= &lock_d;
        end
    end

`ifdef CTRL_LOCK_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign enable_all = enable_q;
    assign lock_on    = lock_q;
    assign cmd_err    = cmd_err_q;
    assign all_locked = all_locked_q;

endmodule

// File: tb/tb_ctrl_lock_decoder.sv
// Randomized and directed bench for ctrl_lock_decoder against a per-channel behavioural model.
// Define CTRL_LOCK_ERRCNT_EN for both bench and RTL to check the saturating error counter.
module tb_ctrl_lock_decoder;

    localparam int NCH = 4;
    localparam int CW  = 3;   // wide enough to present out-of-range channel indices

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_bcast = 1'b0;
    logic [CW-1:0]  cmd_ch = '0;
    logic [3:0]     cmd_code = '0;
    logic [NCH-1:0] enable_all;
    logic [NCH-1:0] lock_on;
    logic           cmd_err;
    logic           all_locked;
    logic [7:0]     err_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // model: 0 = disabled, 1 = enabled, 2 = locked
    int m_state [NCH];
    int m_err;
    int m_cnt;

    ctrl_lock_decoder #(.CTRL_W(4), .NUM_CH(NCH), .CH_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_bcast  (cmd_bcast),
        .cmd_ch     (cmd_ch),
        .cmd_code   (cmd_code),
        .enable_all (enable_all),
        .lock_on    (lock_on),
        .cmd_err    (cmd_err),
        .all_locked (all_locked),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input bit b, input int ch, input int code);
        bit code_ok;
        bit rej;
        int n_unlocked;
        if (r) begin
            foreach (m_state[i]) m_state[i] = 0;
            m_err = 0;
            m_cnt = 0;
            return;
        end
        m_err = 0;
        if (!v) return;
        code_ok = (code >= 1) && (code <= 3);
        n_unlocked = 0;
        foreach (m_state[i]) if (m_state[i] != 2) n_unlocked++;
        if (b) rej = !code_ok || (n_unlocked == 0);
        else   rej = !code_ok || (ch >= NCH) || (m_state[ch] == 2);
        if (!rej) begin
            foreach (m_state[i])
                if ((b || i == ch) && m_state[i] != 2) m_state[i] = code - 1 + (code == 1 ? 1 : 0) - (code == 2 ? 1 : 0);
        end
        m_err = rej ? 1 : 0;
`ifdef CTRL_LOCK_ERRCNT_EN
        if (rej && m_cnt < 255) m_cnt++;
`endif
    endtask

    task automatic compare_all(input string tag);
        logic [NCH-1:0] e_en;
        logic [NCH-1:0] e_lk;
        for (int i = 0; i < NCH; i++) begin
            e_en[i] = (m_state[i] == 1);
            e_lk[i] = (m_state[i] == 2);
        end
        check({tag, ".en"},   32'(enable_all), 32'(e_en));
        check({tag, ".lk"},   32'(lock_on),    32'(e_lk));
        check({tag, ".err"},  32'(cmd_err),    32'(m_err));
        check({tag, ".all"},  32'(all_locked), 32'(&e_lk));
        check({tag, ".cnt"},  32'(err_cnt),    32'(m_cnt));
    endtask

    task automatic do_cmd(input string tag, input bit r, input bit v, input bit b,
                          input int ch, input int code);
        rst       = r;
        cmd_valid = v;
        cmd_bcast = b;
        cmd_ch    = CW'(ch);
        cmd_code  = 4'(code);
        @(posedge clk);
        model_step(r, v, b, ch, code);
        #1;
        compare_all(tag);
    endtask

    initial begin
        int ch;
        int code;
        #1;
        do_cmd("rst0", 1, 0, 0, 0, 0);
        do_cmd("rst1", 1, 0, 0, 0, 0);
        check("tp_rst_en", 32'(enable_all), 32'h0);

        do_cmd("en2", 0, 1, 0, 2, 1);
        check("tp_en2", 32'(enable_all), 32'h4);
        check("tp_en2_err", 32'(cmd_err), 32'h0);

        do_cmd("en1", 0, 1, 0, 1, 1);
        do_cmd("lk1", 0, 1, 0, 1, 3);
        check("tp_lk1_en", 32'(enable_all[1]), 32'h0);
        check("tp_lk1_lk", 32'(lock_on[1]), 32'h1);
        do_cmd("en1_locked", 0, 1, 0, 1, 1);
        check("tp_locked_err", 32'(cmd_err), 32'h1);
        do_cmd("relock1", 0, 1, 0, 1, 3);
        do_cmd("idle", 0, 0, 0, 1, 3);

        do_cmd("rst2", 1, 0, 0, 0, 0);
        do_cmd("inv0", 0, 1, 0, 0, 0);
        check("tp_inv0_err", 32'(cmd_err), 32'h1);
        do_cmd("inv4", 0, 1, 0, 0, 4);
        do_cmd("inv15", 0, 1, 0, 0, 15);
        do_cmd("badch", 0, 1, 0, 5, 1);
        check("tp_badch_en", 32'(enable_all), 32'h0);
`ifdef CTRL_LOCK_ERRCNT_EN
        check("tp_cnt4", 32'(err_cnt), 32'd4);
`endif

        do_cmd("lk0", 0, 1, 0, 0, 3);
        do_cmd("b_en", 0, 1, 1, 7, 1);
        check("tp_ben_en", 32'(enable_all), 32'he);
        check("tp_ben_lk", 32'(lock_on), 32'h1);
        do_cmd("b_dis", 0, 1, 1, 0, 2);
        do_cmd("b_lk", 0, 1, 1, 0, 3);
        check("tp_blk_all", 32'(all_locked), 32'h1);
        do_cmd("b_en_all_locked", 0, 1, 1, 0, 1);
        check("tp_ball_err", 32'(cmd_err), 32'h1);
        do_cmd("b_inv", 0, 1, 1, 0, 9);

        do_cmd("rst_lk3", 1, 1, 0, 3, 3);
        check("tp_rstcmd_lk", 32'(lock_on), 32'h0);
        do_cmd("en3", 0, 1, 0, 3, 1);
        check("tp_en3", 32'(enable_all[3]), 32'h1);

        for (int k = 0; k < 300; k++) do_cmd("sat", 0, 1, 0, 0, 8 + (k % 8));
`ifdef CTRL_LOCK_ERRCNT_EN
        check("tp_sat", 32'(err_cnt), 32'd255);
`endif
        do_cmd("rst_sat", 1, 0, 0, 0, 0);
        check("tp_sat_clr", 32'(err_cnt), 32'd0);

        for (int k = 0; k < 600; k++) begin
            ch   = $urandom_range(0, 7);
            code = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0 && code == 3) code = $urandom_range(1, 2);
            do_cmd("rnd", ($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0),
                   ($urandom_range(0, 5) == 0), ch, code);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
